// File: rtl/spell_mem_initiator.sv
// rtl/spell_mem_initiator.sv - SPELL memory bus master arbitrating fetch and load/store with timeout
module spell_mem_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_req,
    input  logic [7:0] fetch_addr,
    output logic       fetch_ack,
    output logic [7:0] fetch_data,
    input  logic       dreq,
    input  logic       dwrite,
    input  logic [7:0] daddr,
    input  logic [7:0] dwdata,
    output logic       dack,
    output logic [7:0] drdata,
    output logic       bus_err,
    output logic       busy,
    output logic       mem_select,
    output logic       mem_write,
    output logic       mem_type_data,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_data_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 2);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          last_data;
    logic          grant_data;
    logic          pick_data;
    logic          timed_out;

    // Data wins unless it was granted last time and fetch is also waiting.
    assign pick_data = dreq && (!fetch_req || !last_data);
    assign timed_out = (TIMEOUT_CYCLES != 0) && ((cnt + CW'(1)) == TMO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            last_data     <= 1'b0;
            grant_data    <= 1'b0;
            fetch_ack     <= 1'b0;
            fetch_data    <= 8'h00;
            dack          <= 1'b0;
            drdata        <= 8'h00;
            bus_err       <= 1'b0;
            busy          <= 1'b0;
            mem_select    <= 1'b0;
            mem_write     <= 1'b0;
            mem_type_data <= 1'b0;
            mem_addr      <= 8'h00;
            mem_wdata     <= 8'h00;
        end else begin
            fetch_ack <= 1'b0;
            dack      <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                IDLE: begin
                    // A responder still asserting ready from a previous access blocks new grants.
                    if (!mem_data_ready && (fetch_req || dreq)) begin
                        grant_data    <= pick_data;
                        last_data     <= pick_data;
                        mem_select    <= 1'b1;
                        mem_type_data <= pick_data;
                        mem_write     <= pick_data && dwrite;
                        mem_addr      <= pick_data ? daddr : fetch_addr;
                        mem_wdata     <= pick_data ? dwdata : 8'h00;
                        cnt           <= '0;
                        busy          <= 1'b1;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + CW'(1);
                    if (mem_data_ready || timed_out) begin
                        mem_select <= 1'b0;
                        bus_err    <= !mem_data_ready;
                        state      <= RELEASE;
                        if (grant_data) begin
                            dack   <= 1'b1;
                            drdata <= !mem_data_ready ? 8'hFF :
                                      (mem_write ? 8'h00 : mem_rdata);
                        end else begin
                            fetch_ack  <= 1'b1;
                            fetch_data <= mem_data_ready ? mem_rdata : 8'hFF;
                        end
                    end
                end
                RELEASE: begin
                    if (!mem_data_ready) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spell_mem_initiator.sv
// tb/tb_spell_mem_initiator.sv - randomized self-checking bench for spell_mem_initiator
module tb_spell_mem_initiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       fetch_req, dreq, dwrite;
    logic [7:0] fetch_addr, daddr, dwdata;
    logic       fetch_ack, dack, bus_err, busy;
    logic [7:0] fetch_data, drdata;
    logic       mem_select, mem_write, mem_type_data;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       mem_data_ready = 1'b0;

    logic       t_fetch_req, t_dreq, t_dwrite;
    logic [7:0] t_fetch_addr, t_daddr, t_dwdata;
    logic       t_fetch_ack, t_dack, t_bus_err, t_busy;
    logic [7:0] t_fetch_data, t_drdata;
    logic       t_select, t_write, t_type;
    logic [7:0] t_addr, t_wdata;
    logic [7:0] t_rdata;
    logic       t_ready;

    int errors = 0;
    int checks = 0;

    spell_mem_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack), .fetch_data(fetch_data),
        .dreq(dreq), .dwrite(dwrite), .daddr(daddr), .dwdata(dwdata), .dack(dack), .drdata(drdata),
        .bus_err(bus_err), .busy(busy),
        .mem_select(mem_select), .mem_write(mem_write), .mem_type_data(mem_type_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_data_ready(mem_data_ready)
    );

    spell_mem_initiator #(.TIMEOUT_CYCLES(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(t_fetch_req), .fetch_addr(t_fetch_addr), .fetch_ack(t_fetch_ack), .fetch_data(t_fetch_data),
        .dreq(t_dreq), .dwrite(t_dwrite), .daddr(t_daddr), .dwdata(t_dwdata), .dack(t_dack), .drdata(t_drdata),
        .bus_err(t_bus_err), .busy(t_busy),
        .mem_select(t_select), .mem_write(t_write), .mem_type_data(t_type),
        .mem_addr(t_addr), .mem_wdata(t_wdata), .mem_rdata(t_rdata), .mem_data_ready(t_ready)
    );

    // Responder: 32-cycle init after reset, configurable wait states, optional stuck ready.
    logic [7:0] code_mem [256];
    logic [7:0] data_mem [256];
    logic [7:0] code_ref [256];
    logic [7:0] data_ref [256];
    int resp_lat = 0;
    int resp_wait = 0;
    int resp_init = 0;
    bit resp_stuck = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_data_ready <= 1'b0;
            resp_init      <= 0;
            resp_wait      <= 0;
        end else begin
            if (resp_init < 32) resp_init <= resp_init + 1;
            if (resp_stuck) mem_data_ready <= 1'b1;
            else if (!mem_select) begin
                mem_data_ready <= 1'b0;
                resp_wait      <= 0;
            end else if (!mem_data_ready && resp_init >= 32) begin
                if (resp_wait >= resp_lat) begin
                    mem_data_ready <= 1'b1;
                    if (mem_type_data) begin
                        mem_rdata <= data_mem[mem_addr];
                        if (mem_write) data_mem[mem_addr] <= mem_wdata;
                    end else begin
                        mem_rdata <= code_mem[mem_addr];
                    end
                end else begin
                    resp_wait <= resp_wait + 1;
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (!busy && !mem_data_ready) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b ready=%0b required idle", busy, mem_data_ready);
        end
    endtask

    task automatic do_req(input bit is_data, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                          output bit got, output logic [7:0] rd, output bit err, output int cyc);
        fetch_req = !is_data; dreq = is_data; dwrite = wr;
        fetch_addr = a; daddr = a; dwdata = wd;
        got = 1'b0; rd = 8'h00; err = 1'b0; cyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (is_data ? dack : fetch_ack) begin
                got = 1'b1;
                rd  = is_data ? drdata : fetch_data;
                err = bus_err;
            end
        end
        fetch_req = 1'b0; dreq = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({fetch_ack, dack, bus_err, busy, mem_select, mem_write, mem_type_data} !== 7'd0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 0", {fetch_ack, dack, bus_err, busy, mem_select, mem_write, mem_type_data});
        end
        checks++;
        if ({mem_addr, mem_wdata, fetch_data, drdata} !== 32'd0) begin
            errors++; $display("FAIL reset_data: got %h required 0", {mem_addr, mem_wdata, fetch_data, drdata});
        end
        checks++;
        if ({t_fetch_ack, t_dack, t_bus_err, t_busy, t_select} !== 5'd0) begin
            errors++; $display("FAIL reset_dut8: got %b required 0", {t_fetch_ack, t_dack, t_bus_err, t_busy, t_select});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_init_wait();
        bit got, err; logic [7:0] rd; int cyc;
        @(negedge clk);
        do_req(1'b0, 1'b0, 8'h85, 8'h00, got, rd, err, cyc);
        checks++;
        if (!got || err !== 1'b0) begin
            errors++; $display("FAIL init_fetch_status: got=%0b err=%0b required got=1 err=0", got, err);
        end
        checks++;
        if (rd !== code_ref[8'h85]) begin
            errors++; $display("FAIL init_fetch_data: got %h required %h", rd, code_ref[8'h85]);
        end
        checks++;
        if (cyc < 30 || cyc > 40) begin
            errors++; $display("FAIL init_fetch_latency: got %0d required 30..40", cyc);
        end
        checks++;
        if ({mem_type_data, mem_write, mem_addr} !== {2'b00, 8'h85}) begin
            errors++; $display("FAIL init_fetch_bus: got %h required %h", {mem_type_data, mem_write, mem_addr}, {2'b00, 8'h85});
        end
    endtask

    task automatic test_fetch();
        bit got, err; logic [7:0] rd, a; int cyc;
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 8'h85 : 8'($urandom);
            wait_idle();
            do_req(1'b0, 1'b0, a, 8'h00, got, rd, err, cyc);
            checks++;
            if (!got || err || rd !== code_ref[a] || cyc != 3) begin
                errors++; $display("FAIL fetch[%0d]: got=%0b err=%0b data=%h cyc=%0d required data=%h cyc=3", i, got, err, rd, cyc, code_ref[a]);
            end
            @(negedge clk);
            checks++;
            if (fetch_ack !== 1'b0 || fetch_data !== code_ref[a]) begin
                errors++; $display("FAIL fetch_hold[%0d]: ack=%0b data=%h required ack=0 data=%h", i, fetch_ack, fetch_data, code_ref[a]);
            end
        end
    endtask

    task automatic test_store_load();
        bit got, err, wr; logic [7:0] rd, a, wd; int cyc;
        wait_idle();
        do_req(1'b1, 1'b1, 8'h07, 8'h5A, got, rd, err, cyc);
        checks++;
        if (!got || err || rd !== 8'h00 || {mem_type_data, mem_write, mem_select} !== 3'b110) begin
            errors++; $display("FAIL store_07: got=%0b err=%0b rd=%h bus=%b required 1 0 00 110", got, err, rd, {mem_type_data, mem_write, mem_select});
        end
        if (got && !err) data_ref[8'h07] = 8'h5A;
        do_req(1'b1, 1'b0, 8'h07, 8'h00, got, rd, err, cyc);
        checks++;
        if (!got || err || rd !== 8'h5A) begin
            errors++; $display("FAIL load_07: got=%0b err=%0b rd=%h required rd=5a", got, err, rd);
        end
        checks++;
        if (cyc != 5) begin
            errors++; $display("FAIL back_to_back_spacing: got %0d required 5", cyc);
        end
        for (int i = 0; i < 12; i++) begin
            wr = 1'($urandom);
            a  = 8'($urandom_range(0, 7));
            wd = 8'($urandom);
            wait_idle();
            do_req(1'b1, wr, a, wd, got, rd, err, cyc);
            checks++;
            if (!got || err || rd !== (wr ? 8'h00 : data_ref[a])) begin
                errors++; $display("FAIL rand_data[%0d]: wr=%0b addr=%h got=%0b err=%0b rd=%h required %h", i, wr, a, got, err, rd, wr ? 8'h00 : data_ref[a]);
            end
            if (wr) data_ref[a] = wd;
        end
    endtask

    task automatic test_latency();
        bit got, err; logic [7:0] rd, a; int cyc;
        resp_lat = 3;
        a = 8'($urandom);
        wait_idle();
        do_req(1'b0, 1'b0, a, 8'h00, got, rd, err, cyc);
        checks++;
        if (!got || err || rd !== code_ref[a] || cyc != 6) begin
            errors++; $display("FAIL latency3_fetch: got=%0b err=%0b rd=%h cyc=%0d required rd=%h cyc=6", got, err, rd, cyc, code_ref[a]);
        end
        wait_idle();
        do_req(1'b1, 1'b0, 8'h03, 8'h00, got, rd, err, cyc);
        checks++;
        if (!got || err || rd !== data_ref[8'h03] || cyc != 6) begin
            errors++; $display("FAIL latency3_load: got=%0b err=%0b rd=%h cyc=%0d required rd=%h cyc=6", got, err, rd, cyc, data_ref[8'h03]);
        end
        resp_lat = 0;
    endtask

    task automatic test_stuck_ready();
        bit granted = 1'b0; bit got, err; logic [7:0] rd; int cyc;
        wait_idle();
        resp_stuck = 1'b1;
        @(negedge clk);
        fetch_addr = 8'h42; fetch_req = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (busy || mem_select) granted = 1'b1;
        end
        checks++;
        if (granted) begin
            errors++; $display("FAIL stuck_ready_grant: got grant required none");
        end
        resp_stuck = 1'b0;
        do_req(1'b0, 1'b0, 8'h42, 8'h00, got, rd, err, cyc);
        checks++;
        if (!got || err || rd !== code_ref[8'h42] || cyc != 4) begin
            errors++; $display("FAIL stuck_ready_release: got=%0b err=%0b rd=%h cyc=%0d required rd=%h cyc=4", got, err, rd, cyc, code_ref[8'h42]);
        end
    endtask

    task automatic test_timeout();
        bit got, err; logic [7:0] rd; int sc;
        t_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            t_dreq = (k == 0); t_fetch_req = (k == 1); t_dwrite = 1'b0;
            got = 1'b0; sc = 0; rd = 8'h00; err = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk);
                if (k == 0 ? t_dack : t_fetch_ack) begin
                    got = 1'b1; err = t_bus_err; rd = (k == 0) ? t_drdata : t_fetch_data;
                end else if (t_select) sc++;
            end
            t_dreq = 1'b0; t_fetch_req = 1'b0;
            checks++;
            if (!got || err !== 1'b1 || rd !== 8'hFF || sc != 8) begin
                errors++; $display("FAIL timeout[%0d]: got=%0b err=%0b rd=%h sel_cycles=%0d required 1 1 ff 8", k, got, err, rd, sc);
            end
            @(negedge clk);
            checks++;
            if ({t_dack, t_fetch_ack, t_bus_err, t_select} !== 4'b0000) begin
                errors++; $display("FAIL timeout_pulse[%0d]: got %b required 0000", k, {t_dack, t_fetch_ack, t_bus_err, t_select});
            end
            @(negedge clk);
            checks++;
            if (t_busy !== 1'b0) begin
                errors++; $display("FAIL timeout_idle[%0d]: busy=%0b required 0", k, t_busy);
            end
        end
        // Ready arriving on the very edge the counter expires must win.
        t_rdata = 8'hC3; t_fetch_req = 1'b1; got = 1'b0; sc = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (t_fetch_ack) begin
                got = 1'b1; err = t_bus_err; rd = t_fetch_data;
            end else if (t_select) begin
                sc++;
                if (sc == 8) t_ready = 1'b1;
            end
        end
        t_fetch_req = 1'b0; t_ready = 1'b0;
        checks++;
        if (!got || err !== 1'b0 || rd !== 8'hC3) begin
            errors++; $display("FAIL ready_beats_timeout: got=%0b err=%0b rd=%h required 1 0 c3", got, err, rd);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n = 0; int last_cyc = 0; bit both = 1'b0; bit wide = 1'b0; bit prev_f = 1'b0; bit prev_d = 1'b0;
        bit expect_data = 1'b1;
        rst_n = 1'b0;
        fetch_addr = 8'h10; daddr = 8'h20; dwrite = 1'b0;
        fetch_req = 1'b1; dreq = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 300 && n < 6; c++) begin
            @(negedge clk);
            if (fetch_ack && dack) both = 1'b1;
            if ((fetch_ack && prev_f) || (dack && prev_d)) wide = 1'b1;
            prev_f = fetch_ack; prev_d = dack;
            if (fetch_ack || dack) begin
                checks++;
                if (dack !== expect_data) begin
                    errors++; $display("FAIL rr_order[%0d]: dack=%0b required %0b", n, dack, expect_data);
                end
                checks++;
                if ((dack ? drdata : fetch_data) !== (dack ? data_ref[8'h20] : code_ref[8'h10]) || bus_err) begin
                    errors++; $display("FAIL rr_data[%0d]: got %h err=%0b required %h", n, dack ? drdata : fetch_data, bus_err, dack ? data_ref[8'h20] : code_ref[8'h10]);
                end
                if (n > 0) begin
                    checks++;
                    if (c - last_cyc != 5) begin
                        errors++; $display("FAIL rr_spacing[%0d]: got %0d required 5", n, c - last_cyc);
                    end
                end
                last_cyc = c;
                expect_data = !expect_data;
                n++;
            end
        end
        fetch_req = 1'b0; dreq = 1'b0;
        checks++;
        if (n != 6 || both || wide) begin
            errors++; $display("FAIL rr_summary: acks=%0d both=%0b wide=%0b required 6 0 0", n, both, wide);
        end
    endtask

    task automatic test_reset_mid();
        bit acked = 1'b0; bit got, err; logic [7:0] rd; int cyc;
        wait_idle();
        resp_lat = 10;
        fetch_addr = 8'h99; fetch_req = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_select !== 1'b1) begin
            errors++; $display("FAIL midreset_pre: busy=%0b sel=%0b required 1 1", busy, mem_select);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_select !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_drop: sel=%0b busy=%0b required 0 0", mem_select, busy);
        end
        if (fetch_ack || dack || bus_err) acked = 1'b1;
        fetch_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (fetch_ack || dack || bus_err) acked = 1'b1;
        end
        rst_n = 1'b1;
        resp_lat = 0;
        repeat (3) begin
            @(negedge clk);
            if (fetch_ack || dack || bus_err) acked = 1'b1;
        end
        checks++;
        if (acked) begin
            errors++; $display("FAIL midreset_noack: got ack required none");
        end
        do_req(1'b0, 1'b0, 8'h99, 8'h00, got, rd, err, cyc);
        checks++;
        if (!got || err || rd !== code_ref[8'h99]) begin
            errors++; $display("FAIL midreset_recover: got=%0b err=%0b rd=%h required %h", got, err, rd, code_ref[8'h99]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            code_mem[i] = 8'($urandom); code_ref[i] = code_mem[i];
            data_mem[i] = 8'($urandom); data_ref[i] = data_mem[i];
        end
        rst_n = 1'b0;
        fetch_req = 1'b0; dreq = 1'b0; dwrite = 1'b0;
        fetch_addr = 8'h00; daddr = 8'h00; dwdata = 8'h00;
        t_fetch_req = 1'b0; t_dreq = 1'b0; t_dwrite = 1'b0;
        t_fetch_addr = 8'h11; t_daddr = 8'h33; t_dwdata = 8'h00;
        t_rdata = 8'h00; t_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_init_wait();
        test_fetch();
        test_store_load();
        test_latency();
        test_stuck_ready();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
